// File: rtl/booleanfn_sweep_ctrl.sv
// Sweeps an N-input boolean function through every input vector in order,
// captures its truth table and compares it against an expected minterm mask.
module booleanfn_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [(1<<N_IN)-1:0] expected,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [(1<<N_IN)-1:0] tt,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err,
    output logic                 first_err_valid
);

    localparam int V = 1 << N_IN;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0] ERR_ONE = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [V-1:0]    exp_q;
    logic [V-1:0]    tt_q;
    logic [N_IN-1:0] idx_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] first_err_q;
    logic [N_IN:0]   err_q;
    logic [3:0]      cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            fev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            tt_q        <= '0;
            idx_q       <= '0;
            vec_q       <= '0;
            first_err_q <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fev_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                // Partial tt/err_count are kept for inspection after abort
                state_q <= S_IDLE;
                vec_q   <= '0;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state_q     <= S_SETTLE;
                            exp_q       <= expected;
                            tt_q        <= '0;
                            err_q       <= '0;
                            first_err_q <= '0;
                            fev_q       <= 1'b0;
                            pass_q      <= 1'b0;
                            idx_q       <= '0;
                            vec_q       <= '0;
                            cnt_q       <= CNT_INIT;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == 4'd0) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_SAMPLE: begin
                        tt_q[idx_q] <= y_in;
                        if (y_in != exp_q[idx_q]) begin
                            err_q <= err_q + ERR_ONE;
                            if (!fev_q) begin
                                first_err_q <= idx_q;
                                fev_q       <= 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                            vec_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETTLE;
                            idx_q   <= idx_q + IDX_ONE;
                            vec_q   <= idx_q + IDX_ONE;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_q == '0);
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign tt              = tt_q;
    assign err_count       = err_q;
    assign first_err       = first_err_q;
    assign first_err_valid = fev_q;

endmodule

// File: tb/tb_booleanfn_sweep_ctrl.sv
// Directed bench for booleanfn_sweep_ctrl with a behavioural function
// y_in = fn[vec]; expected values are hand-derived for N_IN=4, SETTLE=1.
module tb_booleanfn_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic        y_in;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [4:0]  err_count;
    logic [3:0]  first_err;
    logic        first_err_valid;
    logic [15:0] fn;

    int total = 0;
    int bad   = 0;

    booleanfn_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .expected(expected),
        .y_in(y_in),
        .vec(vec),
        .busy(busy),
        .done(done),
        .pass(pass),
        .tt(tt),
        .err_count(err_count),
        .first_err(first_err),
        .first_err_valid(first_err_valid)
    );

    assign y_in = fn[vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start across one edge (edge T); returns just after edge T.
    task automatic kick(input logic [15:0] e);
        @(negedge clk);
        expected = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Step n edges, noting where done is seen (k counts edges after T).
    task automatic watch(input int n, output int first_k, output int ndone);
        first_k = -1;
        ndone = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_k < 0) first_k = k;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'($urandom);
            abort = 1'($urandom);
            expected = 16'($urandom);
            fn = 16'($urandom);
            #1;
            total++;
            if ({vec, busy, done, pass, tt, err_count, first_err,
                 first_err_valid} !== 33'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got vec=%h busy=%b tt=%h err=%0d want all 0",
                         c, vec, busy, tt, err_count);
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        fn = 16'hA5C3;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || vec !== 4'd0) begin
                bad++;
                $display("FAIL idle_after_reset got busy=%b vec=%h want 0 0", busy, vec);
            end
        end
    endtask

    task automatic test_pass_sweep;
        int fk, nd;
        fn = 16'hA5C3;
        kick(16'hA5C3);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise got %b want 1", busy);
        end
        watch(33, fk, nd);
        total++;
        if (fk !== 32 || nd !== 1) begin
            bad++;
            $display("FAIL pass_done_timing got k=%0d n=%0d want k=32 n=1", fk, nd);
        end
        total++;
        if (tt !== 16'hA5C3 || err_count !== 5'd0 || first_err_valid !== 1'b0) begin
            bad++;
            $display("FAIL pass_results got tt=%h err=%0d fev=%b want a5c3 0 0",
                     tt, err_count, first_err_valid);
        end
        total++;
        if (pass !== 1'b1 || busy !== 1'b0 || vec !== 4'd0) begin
            bad++;
            $display("FAIL pass_flag got pass=%b busy=%b vec=%h want 1 0 0", pass, busy, vec);
        end
    endtask

    task automatic test_fail_sweep;
        int fk, nd;
        kick(16'hA5C3 ^ 16'h0410);
        watch(33, fk, nd);
        total++;
        if (fk !== 32 || nd !== 1) begin
            bad++;
            $display("FAIL fail_done_timing got k=%0d n=%0d want k=32 n=1", fk, nd);
        end
        total++;
        if (tt !== 16'hA5C3 || err_count !== 5'd2) begin
            bad++;
            $display("FAIL fail_tt_err got tt=%h err=%0d want a5c3 2", tt, err_count);
        end
        total++;
        if (first_err !== 4'd4 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL fail_first got fe=%0d fev=%b pass=%b want 4 1 0",
                     first_err, first_err_valid, pass);
        end
    endtask

    task automatic test_restart_ignored;
        int fk, nd;
        fk = -1;
        nd = 0;
        kick(16'hA5C3);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) begin
                start = 1'b1;
                expected = 16'h0000;
            end
            if (k == 5) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (fk < 0) fk = k;
            end
        end
        total++;
        if (fk !== 32 || nd !== 1) begin
            bad++;
            $display("FAIL restart_done_timing got k=%0d n=%0d want k=32 n=1", fk, nd);
        end
        total++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            bad++;
            $display("FAIL restart_pass got pass=%b err=%0d want 1 0", pass, err_count);
        end
    endtask

    task automatic test_abort;
        int fk, nd;
        kick(16'hA5C3);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || vec !== 4'd0 || pass !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got busy=%b vec=%h pass=%b done=%b want 0 0 0 0",
                     busy, vec, pass, done);
        end
        total++;
        if (tt !== 16'h0003 || err_count !== 5'd0) begin
            bad++;
            $display("FAIL abort_partial got tt=%h err=%0d want 0003 0", tt, err_count);
        end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_beats_start got busy=%b want 0", busy);
        end
        watch(40, fk, nd);
        total++;
        if (nd !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done got n=%0d busy=%b want 0 0", nd, busy);
        end
        kick(16'hA5C3);
        watch(33, fk, nd);
        total++;
        if (fk !== 32 || pass !== 1'b1 || tt !== 16'hA5C3) begin
            bad++;
            $display("FAIL abort_rerun got k=%0d pass=%b tt=%h want 32 1 a5c3", fk, pass, tt);
        end
    endtask

    task automatic test_async_reset;
        int fk, nd;
        kick(16'hA5C3 ^ 16'h0410);
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vec, busy, done, pass, tt, err_count, first_err,
             first_err_valid} !== 33'd0) begin
            bad++;
            $display("FAIL async_reset got vec=%h busy=%b tt=%h err=%0d fev=%b want all 0",
                     vec, busy, tt, err_count, first_err_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        watch(40, fk, nd);
        total++;
        if (nd !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done got n=%0d busy=%b want 0 0", nd, busy);
        end
        kick(16'hA5C3 ^ 16'h0410);
        watch(33, fk, nd);
        total++;
        if (fk !== 32 || tt !== 16'hA5C3 || err_count !== 5'd2 || first_err !== 4'd4
            || pass !== 1'b0) begin
            bad++;
            $display("FAIL reset_rerun got k=%0d tt=%h err=%0d fe=%0d pass=%b want 32 a5c3 2 4 0",
                     fk, tt, err_count, first_err, pass);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        expected = '0;
        fn = 16'hA5C3;
        test_reset;
        test_pass_sweep;
        test_fail_sweep;
        test_restart_ignored;
        test_abort;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
